// File: rtl/snitch_icache_pkg.sv
// Shared instruction-cache types: event vectors reported by L0/L1 and the
// index map used by the performance-counter unit.
package snitch_icache_pkg;

  localparam int unsigned NumL0Events     = 5;
  localparam int unsigned NumL1Events     = 4;
  localparam int unsigned NumPerfCounters = 9;

  // Field order fixes the packed layout; l0_miss is the MSB.
  typedef struct packed {
    logic l0_miss;
    logic l0_hit;
    logic l0_prefetch;
    logic l0_double_hit;
    logic l0_stall;
  } icache_l0_events_t;

  typedef struct packed {
    logic l1_miss;
    logic l1_hit;
    logic l1_stall;
    logic l1_handler_stall;
  } icache_l1_events_t;

  typedef enum logic [3:0] {
    PerfL0Miss        = 4'd0,
    PerfL0Hit         = 4'd1,
    PerfL0Prefetch    = 4'd2,
    PerfL0DoubleHit   = 4'd3,
    PerfL0Stall       = 4'd4,
    PerfL1Miss        = 4'd5,
    PerfL1Hit         = 4'd6,
    PerfL1Stall       = 4'd7,
    PerfL1HandlerStall = 4'd8
  } icache_perf_idx_e;

  typedef struct packed {
    int unsigned cnt_w;
    bit          saturate;
  } perf_cfg_t;

endpackage

// File: rtl/snitch_icache_perf_cnt.sv
// One performance counter: live accumulator with sticky overflow, plus a
// shadow copy that the read port serves from.
module snitch_icache_perf_cnt #(
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned INC_W    = 2,
  parameter bit          SATURATE = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [INC_W-1:0] inc_i,
  input  logic             clear_i,
  input  logic             snapshot_i,
  output logic             ovf_o,
  output logic [CNT_W-1:0] shadow_o,
  output logic             shadow_ovf_o
);

  logic [CNT_W-1:0] live_q;
  logic [CNT_W:0]   sum;

  assign sum = {1'b0, live_q} + {{(CNT_W + 1 - INC_W){1'b0}}, inc_i};

  // Clear wins over the in-flight increment; overflow stays set until cleared.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      live_q <= '0;
      ovf_o  <= 1'b0;
    end else if (clear_i) begin
      live_q <= '0;
      ovf_o  <= 1'b0;
    end else if (sum[CNT_W]) begin
      live_q <= SATURATE ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
      ovf_o  <= 1'b1;
    end else begin
      live_q <= sum[CNT_W-1:0];
    end
  end

  // Snapshot takes pre-edge values, so a simultaneous clear is still captured.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      shadow_o     <= '0;
      shadow_ovf_o <= 1'b0;
    end else if (snapshot_i) begin
      shadow_o     <= live_q;
      shadow_ovf_o <= ovf_o;
    end
  end

endmodule

// File: rtl/snitch_icache_perf_counters.sv
// Instruction-cache event counters: samples per-port L0 and L1 events,
// accumulates them into nine counters and serves shadow copies over a read port.
module snitch_icache_perf_counters
  import snitch_icache_pkg::*;
#(
  parameter int unsigned NR_FETCH_PORTS = 2,
  parameter int unsigned CNT_W          = 32,
  parameter bit          SATURATE       = 1'b0
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  icache_l0_events_t [NR_FETCH_PORTS-1:0] l0_events_i,
  input  icache_l1_events_t                      l1_events_i,
  input  logic                                   enable_i,
  input  logic                                   clear_i,
  input  logic                                   snapshot_i,
  input  logic                                   rd_valid_i,
  input  logic [3:0]                             rd_addr_i,
  output logic                                   rd_valid_o,
  output logic [CNT_W-1:0]                       rd_data_o,
  output logic                                   rd_ovf_o,
  output logic                                   rd_err_o,
  output logic [NumPerfCounters-1:0]             ovf_o
);

  localparam int unsigned INC_W = $clog2(NR_FETCH_PORTS + 1);

  logic [NumPerfCounters-1:0][INC_W-1:0] inc_d;
  logic [NumPerfCounters-1:0][INC_W-1:0] sample_q;
  logic [CNT_W-1:0]                      shadow [NumPerfCounters];
  logic [NumPerfCounters-1:0]            shadow_ovf;

  always_comb begin
    inc_d = '0;
    for (int p = 0; p < int'(NR_FETCH_PORTS); p++) begin
      inc_d[PerfL0Miss]      = inc_d[PerfL0Miss]      + INC_W'(l0_events_i[p].l0_miss);
      inc_d[PerfL0Hit]       = inc_d[PerfL0Hit]       + INC_W'(l0_events_i[p].l0_hit);
      inc_d[PerfL0Prefetch]  = inc_d[PerfL0Prefetch]  + INC_W'(l0_events_i[p].l0_prefetch);
      inc_d[PerfL0DoubleHit] = inc_d[PerfL0DoubleHit] + INC_W'(l0_events_i[p].l0_double_hit);
      inc_d[PerfL0Stall]     = inc_d[PerfL0Stall]     + INC_W'(l0_events_i[p].l0_stall);
    end
    inc_d[PerfL1Miss]         = INC_W'(l1_events_i.l1_miss);
    inc_d[PerfL1Hit]          = INC_W'(l1_events_i.l1_hit);
    inc_d[PerfL1Stall]        = INC_W'(l1_events_i.l1_stall);
    inc_d[PerfL1HandlerStall] = INC_W'(l1_events_i.l1_handler_stall);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sample_q <= '0;
    end else if (enable_i && !clear_i) begin
      sample_q <= inc_d;
    end else begin
      sample_q <= '0;
    end
  end

  for (genvar i = 0; i < int'(NumPerfCounters); i++) begin : gen_cnt
    snitch_icache_perf_cnt #(
      .CNT_W   (CNT_W),
      .INC_W   (INC_W),
      .SATURATE(SATURATE)
    ) i_cnt (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .inc_i       (sample_q[i]),
      .clear_i     (clear_i),
      .snapshot_i  (snapshot_i),
      .ovf_o       (ovf_o[i]),
      .shadow_o    (shadow[i]),
      .shadow_ovf_o(shadow_ovf[i])
    );
  end

  // Response data holds its last value while no read is outstanding.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_valid_o <= 1'b0;
      rd_data_o  <= '0;
      rd_ovf_o   <= 1'b0;
      rd_err_o   <= 1'b0;
    end else begin
      rd_valid_o <= rd_valid_i;
      if (rd_valid_i) begin
        if (rd_addr_i < 4'(NumPerfCounters)) begin
          rd_data_o <= shadow[rd_addr_i];
          rd_ovf_o  <= shadow_ovf[rd_addr_i];
          rd_err_o  <= 1'b0;
        end else begin
          rd_data_o <= '0;
          rd_ovf_o  <= 1'b0;
          rd_err_o  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_snitch_icache_perf_counters.sv
// Bench for snitch_icache_perf_counters: a wrapping and a saturating 8-bit
// instance share stimulus and are compared against event-total bookkeeping.
module tb_snitch_icache_perf_counters;
  import snitch_icache_pkg::*;

  localparam int NP = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  icache_l0_events_t [NP-1:0] l0_events = '0;
  icache_l1_events_t l1_events = '0;
  logic enable = 1'b0, clear = 1'b0, snapshot = 1'b0, rd_valid = 1'b0;
  logic [3:0] rd_addr = '0;

  logic       rd_valid_w, rd_ovf_w, rd_err_w;
  logic [7:0] rd_data_w;
  logic [8:0] ovf_w;
  logic       rd_valid_s, rd_ovf_s, rd_err_s;
  logic [7:0] rd_data_s;
  logic [8:0] ovf_s;

  always #5 clk = ~clk;

  snitch_icache_perf_counters #(.NR_FETCH_PORTS(NP), .CNT_W(8), .SATURATE(1'b0)) dut_wrap (
    .clk_i(clk), .rst_i(rst), .l0_events_i(l0_events), .l1_events_i(l1_events),
    .enable_i(enable), .clear_i(clear), .snapshot_i(snapshot),
    .rd_valid_i(rd_valid), .rd_addr_i(rd_addr),
    .rd_valid_o(rd_valid_w), .rd_data_o(rd_data_w), .rd_ovf_o(rd_ovf_w),
    .rd_err_o(rd_err_w), .ovf_o(ovf_w)
  );

  snitch_icache_perf_counters #(.NR_FETCH_PORTS(NP), .CNT_W(8), .SATURATE(1'b1)) dut_sat (
    .clk_i(clk), .rst_i(rst), .l0_events_i(l0_events), .l1_events_i(l1_events),
    .enable_i(enable), .clear_i(clear), .snapshot_i(snapshot),
    .rd_valid_i(rd_valid), .rd_addr_i(rd_addr),
    .rd_valid_o(rd_valid_s), .rd_data_o(rd_data_s), .rd_ovf_o(rd_ovf_s),
    .rd_err_o(rd_err_s), .ovf_o(ovf_s)
  );

  int test_cnt = 0;
  int fail_cnt = 0;

  // Reference: unbounded event totals since the last clear; counter views derive from them.
  longint total [9];
  longint pending [9];
  logic [7:0] sh_w [9];
  logic [7:0] sh_s [9];
  bit         sh_ovf [9];
  bit         exp_valid;
  logic [7:0] exp_data_w, exp_data_s;
  bit         exp_rovf, exp_err;

  function automatic logic [7:0] view(longint t, bit sat);
    if (sat) return (t > 255) ? 8'd255 : 8'(t);
    return 8'(t % 256);
  endfunction

  function automatic logic [8:0] exp_ovf();
    logic [8:0] v;
    for (int i = 0; i < 9; i++) v[i] = (total[i] >= 256);
    return v;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 9; i++) begin
      total[i] = 0; pending[i] = 0; sh_w[i] = 0; sh_s[i] = 0; sh_ovf[i] = 0;
    end
    exp_valid = 0; exp_data_w = 0; exp_data_s = 0; exp_rovf = 0; exp_err = 0;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    test_cnt++;
    if (obs !== exp) begin
      fail_cnt++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic applyStimulus(input icache_l0_events_t [NP-1:0] l0, input icache_l1_events_t l1,
                               input bit en, input bit clr, input bit snap,
                               input bit rv, input logic [3:0] addr);
    longint ev [9];
    l0_events = l0; l1_events = l1; enable = en; clear = clr;
    snapshot = snap; rd_valid = rv; rd_addr = addr;
    for (int i = 0; i < 9; i++) ev[i] = 0;
    for (int p = 0; p < NP; p++) begin
      ev[0] += l0[p].l0_miss;   ev[1] += l0[p].l0_hit; ev[2] += l0[p].l0_prefetch;
      ev[3] += l0[p].l0_double_hit; ev[4] += l0[p].l0_stall;
    end
    ev[5] = l1.l1_miss; ev[6] = l1.l1_hit; ev[7] = l1.l1_stall; ev[8] = l1.l1_handler_stall;
    exp_valid = rv;
    if (rv) begin
      if (addr < 9) begin
        exp_data_w = sh_w[addr]; exp_data_s = sh_s[addr]; exp_rovf = sh_ovf[addr]; exp_err = 0;
      end else begin
        exp_data_w = 0; exp_data_s = 0; exp_rovf = 0; exp_err = 1;
      end
    end
    if (snap)
      for (int i = 0; i < 9; i++) begin
        sh_w[i] = view(total[i], 0); sh_s[i] = view(total[i], 1); sh_ovf[i] = (total[i] >= 256);
      end
    for (int i = 0; i < 9; i++) begin
      total[i] = clr ? 0 : total[i] + pending[i];
      pending[i] = (en && !clr) ? ev[i] : 0;
    end
    @(posedge clk); #1;
    checkOutput("valid_w", 32'(rd_valid_w), 32'(exp_valid));
    checkOutput("valid_s", 32'(rd_valid_s), 32'(exp_valid));
    checkOutput("data_w", 32'(rd_data_w), 32'(exp_data_w));
    checkOutput("data_s", 32'(rd_data_s), 32'(exp_data_s));
    checkOutput("rovf_w", 32'(rd_ovf_w), 32'(exp_rovf));
    checkOutput("rovf_s", 32'(rd_ovf_s), 32'(exp_rovf));
    checkOutput("err_w", 32'(rd_err_w), 32'(exp_err));
    checkOutput("err_s", 32'(rd_err_s), 32'(exp_err));
    checkOutput("ovf_w", 32'(ovf_w), 32'(exp_ovf()));
    checkOutput("ovf_s", 32'(ovf_s), 32'(exp_ovf()));
  endtask

  icache_l0_events_t [NP-1:0] z0;
  icache_l0_events_t [NP-1:0] l0v;
  icache_l1_events_t z1;
  icache_l1_events_t l1v;

  initial begin
    z0 = '0; z1 = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_valid", 32'(rd_valid_w), 32'd0);
    checkOutput("reset_ovf", 32'(ovf_s), 32'd0);
    rst = 1'b0;

    for (int a = 0; a < 9; a++) applyStimulus(z0, z1, 1, 0, 0, 1, 4'(a));
    applyStimulus(z0, z1, 1, 0, 0, 0, 4'd0);

    l0v = '0; l0v[0].l0_hit = 1'b1; l0v[1].l0_hit = 1'b1; l0v[3].l0_hit = 1'b1;
    repeat (10) applyStimulus(l0v, z1, 1, 0, 0, 0, 4'd0);
    applyStimulus(z0, z1, 1, 0, 0, 0, 4'd0);
    applyStimulus(z0, z1, 1, 0, 1, 0, 4'd0);
    applyStimulus(z0, z1, 1, 0, 0, 1, 4'd1);
    checkOutput("hit_total", 32'(rd_data_w), 32'd30);
    applyStimulus(z0, z1, 1, 0, 0, 1, 4'd0);
    checkOutput("miss_zero", 32'(rd_data_w), 32'd0);

    l1v = '0; l1v.l1_miss = 1'b1;
    for (int k = 0; k < 5; k++) applyStimulus(z0, l1v, (k % 2) == 0, 0, 0, 0, 4'd0);
    applyStimulus(z0, z1, 1, 0, 0, 0, 4'd0);
    applyStimulus(z0, z1, 1, 0, 1, 0, 4'd0);
    applyStimulus(z0, z1, 1, 0, 0, 1, 4'd5);
    checkOutput("l1_miss_gated", 32'(rd_data_w), 32'd3);

    l1v = '0; l1v.l1_stall = 1'b1;
    repeat (257) applyStimulus(z0, l1v, 1, 0, 0, 0, 4'd0);
    applyStimulus(z0, z1, 1, 0, 0, 0, 4'd0);
    checkOutput("stall_ovf_w", 32'(ovf_w[7]), 32'd1);
    checkOutput("stall_ovf_s", 32'(ovf_s[7]), 32'd1);
    applyStimulus(z0, z1, 1, 0, 1, 0, 4'd0);
    applyStimulus(z0, z1, 1, 0, 0, 1, 4'd7);
    checkOutput("stall_wrap", 32'(rd_data_w), 32'd1);
    checkOutput("stall_sat", 32'(rd_data_s), 32'd255);
    checkOutput("stall_rovf", 32'(rd_ovf_s), 32'd1);

    l1v = '0; l1v.l1_hit = 1'b1;
    repeat (13) applyStimulus(z0, l1v, 1, 0, 0, 0, 4'd0);
    applyStimulus(z0, z1, 1, 1, 1, 0, 4'd0);
    checkOutput("clear_ovf", 32'(ovf_w), 32'd0);
    applyStimulus(z0, z1, 1, 0, 0, 1, 4'd6);
    checkOutput("clear_shadow", 32'(rd_data_w), 32'd12);
    applyStimulus(z0, z1, 1, 0, 1, 0, 4'd0);
    applyStimulus(z0, z1, 1, 0, 0, 1, 4'd6);
    checkOutput("clear_live", 32'(rd_data_s), 32'd0);

    for (int c = 0; c < 400; c++) begin
      l0v = 20'($urandom());
      l1v = 4'($urandom());
      applyStimulus(l0v, l1v, $urandom_range(0, 9) != 0, $urandom_range(0, 59) == 0,
                    $urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1,
                    4'($urandom_range(0, 15)));
    end

    applyStimulus(z0, z1, 1, 0, 0, 1, 4'd12);
    checkOutput("err_flag", 32'(rd_err_w), 32'd1);
    checkOutput("err_data", 32'(rd_data_s), 32'd0);
    rd_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    model_reset();
    checkOutput("rst_valid_w", 32'(rd_valid_w), 32'd0);
    checkOutput("rst_valid_s", 32'(rd_valid_s), 32'd0);
    checkOutput("rst_err", 32'(rd_err_w), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) applyStimulus(z0, z1, 1, 0, 0, 0, 4'd0);

    $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
    $finish;
  end

endmodule
